vram_access_arbiter: RTL

//  Shares the single-port text/character RAM between the VGA character fetch (pixel pipeline

---
 rtl/vram_access_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vram_access_arbiter.sv
// Text-RAM slot arbiter: display reads first, buffered editor writes, ordered editor reads.
// Optional WR_BLANK_ONLY_EN: queued writes drain only while in_display is low.
//
//  state  | meaning
//  IDLE   | no RAM cycle next
//  DISP   | display character fetch
//  WR     | drain head of editor write queue
//  RD     | issue the pending editor read
module vram_access_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int WQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_display,
    input  logic                        disp_req,
    input  logic [ADDR_W-1:0]           disp_addr,
    output logic                        disp_valid,
    output logic [DATA_W-1:0]           disp_data,
    input  logic                        ed_req,
    input  logic                        ed_we,
    input  logic [ADDR_W-1:0]           ed_addr,
    input  logic [DATA_W-1:0]           ed_wdata,
    output logic                        ed_ready,
    output logic                        ed_rvalid,
    output logic [DATA_W-1:0]           ed_rdata,
    output logic [$clog2(WQ_DEPTH):0]   wq_count,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_rdata
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DISP, S_WR, S_RD} slot_t;
    slot_t state, state_nxt;

    logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              q_empty, q_full;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic              drain_ok;
    logic              wr_accept, rd_accept, pop;
    logic              ram_en_nxt, ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt;
    logic [DATA_W-1:0] disp_hold, ed_hold;

`ifdef WR_BLANK_ONLY_EN
    assign drain_ok = !in_display;
`else
    logic unused_in_display;
    assign unused_in_display = in_display;
    assign drain_ok = 1'b1;
`endif

    assign q_empty  = (count == '0);
    assign q_full   = (count == CNT_W'(WQ_DEPTH));
    assign wq_count = count;

    // Reads wait for an empty queue so they always observe earlier writes.
    always_comb begin
        ed_ready = 1'b0;
        if (ed_we) ed_ready = !q_full;
        else       ed_ready = q_empty && !rd_pend && (state != S_RD);
    end

    assign wr_accept = ed_req && ed_we && ed_ready;
    assign rd_accept = ed_req && !ed_we && ed_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        if (disp_req)                  state_nxt = S_DISP;
        else if (!q_empty && drain_ok) state_nxt = S_WR;
        else if (rd_pend)              state_nxt = S_RD;
    end

    always_comb begin
        ram_en_nxt    = 1'b1;
        ram_we_nxt    = 1'b0;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        pop           = 1'b0;
        case (state_nxt)
            S_DISP: ram_addr_nxt = disp_addr;
            S_WR: begin
                ram_we_nxt    = 1'b1;
                ram_addr_nxt  = wq_addr[rd_ptr];
                ram_wdata_nxt = wq_data[rd_ptr];
                pop           = 1'b1;
            end
            S_RD:    ram_addr_nxt = rd_addr;
            default: ram_en_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en    <= ram_en_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            wq_addr[wr_ptr] <= ed_addr;
            wq_data[wr_ptr] <= ed_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_accept && !pop)      count <= count + CNT_W'(1);
            else if (!wr_accept && pop) count <= count - CNT_W'(1);
            if (rd_accept) begin
                rd_pend <= 1'b1;
                rd_addr <= ed_addr;
            end else if (state_nxt == S_RD) begin
                rd_pend <= 1'b0;
            end
        end
    end

    // Read data is passed straight through in its valid cycle, then held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_valid <= 1'b0;
            ed_rvalid  <= 1'b0;
            disp_hold  <= '0;
            ed_hold    <= '0;
        end else begin
            disp_valid <= (state == S_DISP);
            ed_rvalid  <= (state == S_RD);
            if (disp_valid) disp_hold <= ram_rdata;
            if (ed_rvalid)  ed_hold   <= ram_rdata;
        end
    end

    assign disp_data = disp_valid ? ram_rdata : disp_hold;
    assign ed_rdata  = ed_rvalid  ? ram_rdata : ed_hold;

endmodule
